// File: rtl/tqvp_wdt_reset_ctrl.sv
// Watchdog reset controller: grace window with interrupt, fixed-width reset pulse, event counter.
// Optional sticky CTRL.LOCK is compiled in when TQVP_WDT_RSTCTL_LOCK_EN is defined.
module tqvp_wdt_reset_ctrl #(
   parameter int PULSE_LEN = 16,
   parameter int CNT_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wdt_timeout,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt,
   output logic        sys_reset_req
);

   localparam logic [5:0]  ADDR_CTRL   = 6'h00;
   localparam logic [5:0]  ADDR_GRACE  = 6'h04;
   localparam logic [5:0]  ADDR_STATUS = 6'h08;
   localparam logic [5:0]  ADDR_CLEAR  = 6'h0C;
   localparam logic [31:0] CLEAR_KEY   = 32'h0000_C1EA;
   localparam logic [7:0]  PULSE_LAST  = 8'(PULSE_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRACE   = 2'd1,
      S_RESET   = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [15:0]       grace_cnt_reg, grace_cnt_next;
   logic [7:0]        pulse_cnt_reg, pulse_cnt_next;
   logic              arm_reg;
   logic [15:0]       grace_len_reg;
   logic [CNT_W-1:0]  reset_count_reg, reset_count_next;
   logic              last_was_reset_reg, last_was_reset_next;
   logic              sys_reset_req_reg, user_interrupt_reg;
   logic              data_ready_reg;
   logic [31:0]       data_out_reg;
   logic [31:0]       rd_data;
   logic [31:0]       status_word;
   logic [31:0]       ctrl_word;
   logic              wr_en, rd_en;
   logic              ctrl_wr, grace_wr, clear_wr;
   logic              enter_reset, tap_in_grace;
   logic              unused_inputs;

   assign wr_en    = (data_write_n != 2'b11);
   assign rd_en    = (data_read_n != 2'b11);
   assign clear_wr = wr_en && (address == ADDR_CLEAR) && (data_in == CLEAR_KEY);
   assign unused_inputs = ^ui_in;

`ifdef TQVP_WDT_RSTCTL_LOCK_EN
   logic lock_reg;

   // Once locked, CTRL and GRACE are frozen until the next rst.
   assign ctrl_wr   = wr_en && (address == ADDR_CTRL) && !lock_reg;
   assign grace_wr  = wr_en && (address == ADDR_GRACE) && !lock_reg;
   assign ctrl_word = {30'd0, lock_reg, arm_reg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_reg <= 1'b0;
      end else if (ctrl_wr && data_in[1]) begin
         lock_reg <= 1'b1;
      end
   end
`else
   assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
   assign grace_wr  = wr_en && (address == ADDR_GRACE);
   assign ctrl_word = {31'd0, arm_reg};
`endif

   always_comb begin
      state_next     = state_reg;
      grace_cnt_next = grace_cnt_reg;
      pulse_cnt_next = pulse_cnt_reg;
      enter_reset    = 1'b0;
      tap_in_grace   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (arm_reg && wdt_timeout) begin
               state_next     = S_GRACE;
               grace_cnt_next = grace_len_reg;
            end
         end
         S_GRACE: begin
            if (!wdt_timeout) begin
               state_next   = S_IDLE;
               tap_in_grace = 1'b1;
            end else if (!arm_reg) begin
               state_next = S_IDLE;
            end else if (grace_cnt_reg == 16'd0) begin
               state_next     = S_RESET;
               pulse_cnt_next = PULSE_LAST;
               enter_reset    = 1'b1;
            end else begin
               grace_cnt_next = grace_cnt_reg - 16'd1;
            end
         end
         S_RESET: begin
            // ARM is deliberately not consulted: a started pulse always completes.
            if (pulse_cnt_reg == 8'd0) begin
               state_next = S_HOLDOFF;
            end else begin
               pulse_cnt_next = pulse_cnt_reg - 8'd1;
            end
         end
         S_HOLDOFF: begin
            if (!wdt_timeout) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // A CLEAR landing on the RESET-entry edge takes priority over the increment.
   always_comb begin
      reset_count_next    = reset_count_reg;
      last_was_reset_next = last_was_reset_reg;
      if (clear_wr) begin
         reset_count_next    = '0;
         last_was_reset_next = 1'b0;
      end else if (enter_reset) begin
         if (reset_count_reg != {CNT_W{1'b1}}) begin
            reset_count_next = reset_count_reg + CNT_W'(1);
         end
         last_was_reset_next = 1'b1;
      end else if (tap_in_grace) begin
         last_was_reset_next = 1'b0;
      end
   end

   always_comb begin
      status_word              = '0;
      status_word[1:0]         = state_reg;
      status_word[2]           = last_was_reset_reg;
      status_word[CNT_W+7:8]   = reset_count_reg;
      case (address)
         ADDR_CTRL:   rd_data = ctrl_word;
         ADDR_GRACE:  rd_data = {16'd0, grace_len_reg};
         ADDR_STATUS: rd_data = status_word;
         ADDR_CLEAR:  rd_data = 32'd0;
         default:     rd_data = 32'hFFFF_FFFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg          <= S_IDLE;
         grace_cnt_reg      <= 16'd0;
         pulse_cnt_reg      <= 8'd0;
         arm_reg            <= 1'b0;
         grace_len_reg      <= 16'd0;
         reset_count_reg    <= '0;
         last_was_reset_reg <= 1'b0;
         sys_reset_req_reg  <= 1'b0;
         user_interrupt_reg <= 1'b0;
         data_ready_reg     <= 1'b0;
         data_out_reg       <= 32'd0;
      end else begin
         state_reg          <= state_next;
         grace_cnt_reg      <= grace_cnt_next;
         pulse_cnt_reg      <= pulse_cnt_next;
         reset_count_reg    <= reset_count_next;
         last_was_reset_reg <= last_was_reset_next;
         // Outputs decoded from the next state so they are clean flop outputs.
         sys_reset_req_reg  <= (state_next == S_RESET);
         user_interrupt_reg <= (state_next == S_GRACE);
         data_ready_reg     <= rd_en;
         data_out_reg       <= rd_en ? rd_data : 32'd0;
         if (ctrl_wr) begin
            arm_reg <= data_in[0];
         end
         if (grace_wr) begin
            grace_len_reg <= data_in[15:0];
         end
      end
   end

   assign sys_reset_req  = sys_reset_req_reg;
   assign user_interrupt = user_interrupt_reg;
   assign data_ready     = data_ready_reg;
   assign data_out       = data_out_reg;
   assign uo_out[0]      = sys_reset_req_reg;
   assign uo_out[1]      = user_interrupt_reg;

   genvar gi;
   generate
      for (gi = 2; gi < 8; gi++) begin : g_uo_zero
         assign uo_out[gi] = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_tqvp_wdt_reset_ctrl.sv
// Bench for tqvp_wdt_reset_ctrl: register table, directed corner sequences, random run vs timestamp model.
module tb_tqvp_wdt_reset_ctrl;

   localparam int P  = 16;
   localparam int CW = 8;
   localparam logic [5:0] A_CTRL   = 6'h00;
   localparam logic [5:0] A_GRACE  = 6'h04;
   localparam logic [5:0] A_STATUS = 6'h08;
   localparam logic [5:0] A_CLEAR  = 6'h0C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wdt_timeout = 1'b0;
   logic [7:0]  ui_in = 8'd0;
   logic [7:0]  uo_out;
   logic [5:0]  address = 6'd0;
   logic [31:0] data_in = 32'd0;
   logic [1:0]  data_write_n = 2'b11;
   logic [1:0]  data_read_n = 2'b11;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;
   logic        sys_reset_req;

   always #5 clk = ~clk;

   tqvp_wdt_reset_ctrl #(.PULSE_LEN(P), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .wdt_timeout(wdt_timeout), .ui_in(ui_in), .uo_out(uo_out),
      .address(address), .data_in(data_in), .data_write_n(data_write_n),
      .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
      .user_interrupt(user_interrupt), .sys_reset_req(sys_reset_req)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else n_pass++;
   endtask

   // Reference model: phase plus absolute edge timestamps for when the window and pulse end.
   int          m_phase;
   longint      m_cyc = 0;
   longint      m_deadline, m_pulse_end;
   logic        m_arm, m_lock;
   logic [15:0] m_grace;
   int          m_count;
   logic        m_lwr;
   logic        m_ready;
   logic [31:0] m_rd;

   task automatic model_reset();
      m_phase = 0; m_arm = 1'b0; m_lock = 1'b0; m_grace = 16'd0;
      m_count = 0; m_lwr = 1'b0; m_ready = 1'b0; m_rd = 32'd0;
   endtask

   function automatic logic [31:0] model_read(input logic [5:0] a);
      case (a)
         A_CTRL:   return {30'd0, m_lock, m_arm};
         A_GRACE:  return {16'd0, m_grace};
         A_STATUS: return 32'(m_phase) | (32'(m_lwr) << 2) | (32'(m_count) << 8);
         A_CLEAR:  return 32'd0;
         default:  return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic model_edge();
      m_cyc++;
      m_ready = (data_read_n != 2'b11);
      m_rd    = m_ready ? model_read(address) : 32'd0;
      case (m_phase)
         0: if (m_arm && wdt_timeout) begin
               m_phase = 1;
               m_deadline = m_cyc + longint'(m_grace) + 1;
            end
         1: if (!wdt_timeout) begin
               m_phase = 0; m_lwr = 1'b0;
            end else if (!m_arm) begin
               m_phase = 0;
            end else if (m_cyc == m_deadline) begin
               m_phase = 2; m_pulse_end = m_cyc + P;
               if (m_count < (1 << CW) - 1) m_count++;
               m_lwr = 1'b1;
            end
         2: if (m_cyc == m_pulse_end) m_phase = 3;
         default: if (!wdt_timeout) m_phase = 0;
      endcase
      if (data_write_n != 2'b11) begin
         if (address == A_CTRL && !m_lock) begin
            m_arm = data_in[0];
`ifdef TQVP_WDT_RSTCTL_LOCK_EN
            m_lock = m_lock | data_in[1];
`endif
         end
         if (address == A_GRACE && !m_lock) m_grace = data_in[15:0];
         if (address == A_CLEAR && data_in == 32'h0000C1EA) begin
            m_count = 0; m_lwr = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("outputs", 32'({data_ready, user_interrupt, sys_reset_req, uo_out}),
            32'({m_ready, m_phase == 1, m_phase == 2, 6'b0, m_phase == 1, m_phase == 2}));
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
      address = a; data_in = d; data_write_n = 2'b10;
      tick();
      data_write_n = 2'b11; data_in = 32'd0; address = 6'd0;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
      address = a; data_read_n = 2'b00;
      tick();
      d = data_out;
      check("read_model", data_out, m_rd);
      data_read_n = 2'b11; address = 6'd0;
   endtask

   task automatic wait_srr(input logic val, input int budget);
      int n = 0;
      while (sys_reset_req !== val && n < budget) begin
         tick(); n++;
      end
      if (sys_reset_req !== val) check("wait_srr_budget", 32'(sys_reset_req), 32'(val));
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1 check("async_rst_drop", 32'({sys_reset_req, user_interrupt, uo_out}), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [5:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[12];

   initial begin
      logic [31:0] rd;
      int edges, irq_cyc, pl, seen;
      logic [5:0] ra;
      int r;

      model_reset();
      vecs[0]  = '{1'b0, A_STATUS, 32'd0,          32'h0000_0000};
      vecs[1]  = '{1'b0, A_CTRL,   32'd0,          32'h0000_0000};
      vecs[2]  = '{1'b0, A_GRACE,  32'd0,          32'h0000_0000};
      vecs[3]  = '{1'b1, A_GRACE,  32'h0001_ABCD,  32'd0};
      vecs[4]  = '{1'b0, A_GRACE,  32'd0,          32'h0000_ABCD};
      vecs[5]  = '{1'b0, 6'h10,    32'd0,          32'hFFFF_FFFF};
      vecs[6]  = '{1'b0, 6'h3F,    32'd0,          32'hFFFF_FFFF};
      vecs[7]  = '{1'b0, 6'h02,    32'd0,          32'hFFFF_FFFF};
      vecs[8]  = '{1'b1, A_CLEAR,  32'h0000_1234,  32'd0};
      vecs[9]  = '{1'b0, A_STATUS, 32'd0,          32'h0000_0000};
      vecs[10] = '{1'b1, A_GRACE,  32'd5,          32'd0};
      vecs[11] = '{1'b0, A_GRACE,  32'd0,          32'h0000_0005};

      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({uo_out, data_ready, user_interrupt, sys_reset_req}), 32'd0);
      check("reset_data_out", data_out, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d);
         else begin
            bus_read(vecs[i].a, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
         end
      end

      // GRACE=5: interrupt for 6 cycles, pulse on edge 7 lasting 16 cycles.
      bus_write(A_CTRL, 32'd1);
      wdt_timeout = 1'b1;
      edges = 0; irq_cyc = 0;
      while (!sys_reset_req && edges < 50) begin
         tick(); edges++;
         if (user_interrupt) irq_cyc++;
      end
      check("pulse_start_g5", edges, 7);
      check("grace_len_g5", irq_cyc, 6);
      pl = 0;
      while (sys_reset_req && pl < 100) begin
         pl++; tick();
      end
      check("pulse_len", pl, P);
      bus_read(A_STATUS, rd);
      check("status_after_pulse", rd, 32'h0000_0107);
      wdt_timeout = 1'b0;
      tick();
      bus_write(A_CLEAR, 32'h0000_C1EA);

      // Tap inside a 100-cycle window.
      bus_write(A_GRACE, 32'd100);
      wdt_timeout = 1'b1;
      seen = 0;
      repeat (40) begin tick(); if (sys_reset_req) seen++; end
      wdt_timeout = 1'b0;
      repeat (3) begin tick(); if (sys_reset_req) seen++; end
      check("tap_no_pulse", seen, 0);
      bus_read(A_STATUS, rd);
      check("status_after_tap", rd, 32'h0);

      // GRACE=0: pulse two edges after timeout.
      bus_write(A_GRACE, 32'd0);
      wdt_timeout = 1'b1;
      edges = 0;
      while (!sys_reset_req && edges < 20) begin tick(); edges++; end
      check("pulse_start_g0", edges, 2);
      wait_srr(1'b0, 40);
      wdt_timeout = 1'b0;
      repeat (2) tick();
      bus_read(A_STATUS, rd);
      check("status_g0", rd, 32'h0000_0104);

      // CLEAR on the RESET-entry edge wins.
      wdt_timeout = 1'b1;
      tick();
      bus_write(A_CLEAR, 32'h0000_C1EA);
      check("clear_edge_srr", 32'(sys_reset_req), 32'd1);
      bus_read(A_STATUS, rd);
      check("clear_wins", rd, 32'h0000_0002);
      wait_srr(1'b0, 40);
      wdt_timeout = 1'b0;
      repeat (2) tick();

      // ARM=0 ignores timeout.
      bus_write(A_CTRL, 32'd0);
      wdt_timeout = 1'b1;
      seen = 0;
      repeat (300) begin tick(); if (user_interrupt || sys_reset_req) seen++; end
      check("disarmed_ignore", seen, 0);
      wdt_timeout = 1'b0;
      tick();

      // Disarm write mid-GRACE.
      bus_write(A_CTRL, 32'd1);
      bus_write(A_GRACE, 32'd50);
      wdt_timeout = 1'b1;
      repeat (10) tick();
      bus_write(A_CTRL, 32'd0);
      seen = 0;
      repeat (100) begin tick(); if (sys_reset_req || user_interrupt) seen++; end
      check("disarm_mid_grace", seen, 0);
      bus_read(A_STATUS, rd);
      check("status_disarm", rd, 32'h0);
      wdt_timeout = 1'b0;
      tick();

      // 256 events saturate the 8-bit counter.
      bus_write(A_CTRL, 32'd1);
      bus_write(A_GRACE, 32'd0);
      for (int k = 0; k < 256; k++) begin
         wdt_timeout = 1'b1;
         wait_srr(1'b1, 10);
         wait_srr(1'b0, 40);
         wdt_timeout = 1'b0;
         repeat (2) tick();
      end
      bus_read(A_STATUS, rd);
      check("saturated", rd, 32'h0000_FF04);
      bus_write(A_CLEAR, 32'h0000_1234);
      bus_read(A_STATUS, rd);
      check("clear_wrong_key", rd, 32'h0000_FF04);
      bus_write(A_CLEAR, 32'h0000_C1EA);
      bus_read(A_STATUS, rd);
      check("clear_key", rd, 32'h0);

      // rst on pulse cycle 3.
      wdt_timeout = 1'b1;
      wait_srr(1'b1, 10);
      repeat (2) tick();
      do_reset();
      repeat (5) tick();
      bus_read(A_STATUS, rd);
      check("post_rst_idle", rd, 32'h0);
      wdt_timeout = 1'b0;
      tick();

      // Randomized run.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) wdt_timeout = ~wdt_timeout;
         r = int'($urandom_range(0, 99));
         if (r < 4) bus_write(A_CTRL, {31'd0, ($urandom_range(0, 3) != 0)});
         else if (r < 6) bus_write(A_GRACE, $urandom_range(0, 12));
         else if (r < 7) bus_write(A_CLEAR, ($urandom_range(0, 1) != 0) ? 32'h0000_C1EA : $urandom);
         else if (r < 17) begin
            case ($urandom_range(0, 3))
               0: ra = A_CTRL;
               1: ra = A_GRACE;
               2: ra = A_STATUS;
               default: ra = 6'h10;
            endcase
            bus_read(ra, rd);
         end else tick();
      end
      wdt_timeout = 1'b0;
      repeat (40) tick();
      do_reset();

      // LOCK behaviour depends on the build.
      bus_write(A_CTRL, 32'd3);
      bus_read(A_CTRL, rd);
`ifdef TQVP_WDT_RSTCTL_LOCK_EN
      check("lock_set", rd, 32'd3);
`else
      check("no_lock_bit", rd, 32'd1);
`endif
      bus_write(A_CTRL, 32'd0);
      bus_write(A_GRACE, 32'd7);
      bus_read(A_CTRL, rd);
`ifdef TQVP_WDT_RSTCTL_LOCK_EN
      check("lock_ctrl_held", rd, 32'd3);
`else
      check("ctrl_cleared", rd, 32'd0);
`endif
      bus_read(A_GRACE, rd);
`ifdef TQVP_WDT_RSTCTL_LOCK_EN
      check("lock_grace_held", rd, 32'd0);
`else
      check("grace_written", rd, 32'd7);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
